// File: rtl/spi_mem_responder.sv
// SPI mode-0 target: decodes 0x03 READ / 0x02 WRITE with a 24-bit address and
// turns the byte stream into single-cycle memory read/write strobes.
module spi_mem_responder #(
    parameter int ADDR_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  sclk_in,
    input  logic                  cs_in,
    input  logic                  mosi_in,
    output logic                  miso_out,
    output logic                  miso_oe_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic                  mem_rd_out,
    input  logic [7:0]            mem_rdata_in,
    output logic                  mem_wr_out,
    output logic [7:0]            mem_wdata_out,
    output logic                  busy_out
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ_DATA,
        ST_WRITE_DATA,
        ST_IGNORE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [SYNC_STAGES-1:0]  r_sclk_sync;
    logic [SYNC_STAGES-1:0]  r_cs_sync;
    logic [SYNC_STAGES-1:0]  r_mosi_sync;
    logic                    r_sclk_prev;
    logic                    r_cs_prev;

    logic [4:0]              r_bit_cnt;
    logic [6:0]              r_shift_in;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_cmd_read;
    logic [7:0]              r_miso_shift;
    logic [7:0]              r_next_byte;
    logic                    r_out_started;
    logic                    r_rd_first;
    logic                    r_rd_d;
    logic                    r_miso;
    logic                    r_miso_oe;
    logic                    r_mem_rd;
    logic                    r_mem_wr;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [7:0]              r_wdata;

    logic                    w_sclk;
    logic                    w_cs;
    logic                    w_mosi;
    logic                    w_sclk_rise;
    logic                    w_sclk_fall;
    logic                    w_cs_rise;
    logic                    w_cs_fall;
    logic [7:0]              w_in_byte;

    // The cs chain resets low so a cs held low across reset never looks like a fall.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_in};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk & r_sclk_prev;
    assign w_cs_rise   = w_cs & ~r_cs_prev;
    assign w_cs_fall   = ~w_cs & r_cs_prev;
    assign w_in_byte   = {r_shift_in, w_mosi};

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_cs_rise) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) w_state_next = ST_CMD;
                end
                ST_CMD: begin
                    if (w_sclk_rise && r_bit_cnt == 5'd7) begin
                        if (w_in_byte == 8'h03 || w_in_byte == 8'h02) w_state_next = ST_ADDR;
                        else w_state_next = ST_IGNORE;
                    end
                end
                ST_ADDR: begin
                    if (w_sclk_rise && r_bit_cnt == 5'd23) begin
                        w_state_next = r_cmd_read ? ST_READ_DATA : ST_WRITE_DATA;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // Memory strobes are one-cycle pulses with no back-pressure; read data is
    // taken exactly one cycle after mem_rd_out (tracked by r_rd_d).
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_bit_cnt     <= '0;
            r_shift_in    <= '0;
            r_addr        <= '0;
            r_cmd_read    <= 1'b0;
            r_miso_shift  <= '0;
            r_next_byte   <= '0;
            r_out_started <= 1'b0;
            r_rd_first    <= 1'b0;
            r_rd_d        <= 1'b0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_addr    <= '0;
            r_wdata       <= '0;
        end else begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_rd_d   <= r_mem_rd;
            if (r_rd_d) begin
                if (r_rd_first) r_miso_shift <= mem_rdata_in;
                else            r_next_byte  <= mem_rdata_in;
            end

            if (w_cs_rise) begin
                r_miso_oe <= 1'b0;
                r_miso    <= 1'b0;
                r_rd_d    <= 1'b0;
                r_bit_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cs_fall) begin
                            r_bit_cnt  <= '0;
                            r_shift_in <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_shift_in <= w_in_byte[6:0];
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt  <= '0;
                                r_cmd_read <= (w_in_byte == 8'h03);
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        // Upper address bits shift straight out of r_addr.
                        if (w_sclk_rise) begin
                            r_addr <= {r_addr[ADDR_WIDTH-2:0], w_mosi};
                            if (r_bit_cnt == 5'd23) begin
                                r_bit_cnt     <= '0;
                                r_out_started <= 1'b0;
                                if (r_cmd_read) begin
                                    r_mem_rd   <= 1'b1;
                                    r_mem_addr <= {r_addr[ADDR_WIDTH-2:0], w_mosi};
                                    r_rd_first <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_READ_DATA: begin
                        if (w_sclk_rise && r_out_started && r_bit_cnt == 5'd0) begin
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= r_addr + ADDR_ONE;
                            r_rd_first <= 1'b0;
                        end
                        if (w_sclk_fall) begin
                            if (!r_out_started) begin
                                r_miso        <= r_miso_shift[7];
                                r_miso_shift  <= {r_miso_shift[6:0], 1'b0};
                                r_miso_oe     <= 1'b1;
                                r_out_started <= 1'b1;
                                r_bit_cnt     <= '0;
                            end else if (r_bit_cnt == 5'd7) begin
                                r_miso       <= r_next_byte[7];
                                r_miso_shift <= {r_next_byte[6:0], 1'b0};
                                r_addr       <= r_addr + ADDR_ONE;
                                r_bit_cnt    <= '0;
                            end else begin
                                r_miso       <= r_miso_shift[7];
                                r_miso_shift <= {r_miso_shift[6:0], 1'b0};
                                r_bit_cnt    <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_WRITE_DATA: begin
                        if (w_sclk_rise) begin
                            r_shift_in <= w_in_byte[6:0];
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt  <= '0;
                                r_mem_wr   <= 1'b1;
                                r_mem_addr <= r_addr;
                                r_wdata    <= w_in_byte;
                                r_addr     <= r_addr + ADDR_ONE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    default: begin
                        r_miso_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign miso_out      = r_miso;
    assign miso_oe_out   = r_miso_oe;
    assign mem_addr_out  = r_mem_addr;
    assign mem_rd_out    = r_mem_rd;
    assign mem_wr_out    = r_mem_wr;
    assign mem_wdata_out = r_wdata;
    assign busy_out      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: an SPI host driver, a small memory model, and
// scoreboards for memory strobes and MISO bytes.
module tb_spi_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        miso_oe;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;
    int hp = 6;

    logic [24:0] exp_q[$];
    logic [7:0]  exp_miso_q[$];
    logic [7:0]  mem [0:65535];

    logic [24:0] mon_act;
    logic [24:0] mon_exp;
    logic [7:0]  rx_byte = 8'h00;
    int          rx_cnt = 0;
    logic [7:0]  rx_exp;
    logic        oe_watch = 1'b0;
    logic        oe_seen = 1'b0;

    spi_mem_responder #(.ADDR_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk_in        (clk),
        .reset_in      (reset),
        .sclk_in       (sclk),
        .cs_in         (cs),
        .mosi_in       (mosi),
        .miso_out      (miso),
        .miso_oe_out   (miso_oe),
        .mem_addr_out  (mem_addr),
        .mem_rd_out    (mem_rd),
        .mem_rdata_in  (mem_rdata),
        .mem_wr_out    (mem_wr),
        .mem_wdata_out (mem_wdata),
        .busy_out      (busy)
    );

    // Clock and synchronous-read memory model.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // Strobe monitor.
    always @(negedge clk) begin
        if (mem_rd || mem_wr) begin
            n_cmp++;
            mon_act = {mem_wr, mem_addr, (mem_wr ? mem_wdata : 8'h00)};
            if (mem_rd && mem_wr) begin
                n_fail++;
                $display("FAIL strobe_overlap: rd=1 wr=1 at addr %04h, required at most one", mem_addr);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_unexpected: got wr=%0b addr=%04h data=%02h, required none",
                         mon_act[24], mon_act[23:8], mon_act[7:0]);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL strobe: got wr=%0b addr=%04h data=%02h, required wr=%0b addr=%04h data=%02h",
                             mon_act[24], mon_act[23:8], mon_act[7:0],
                             mon_exp[24], mon_exp[23:8], mon_exp[7:0]);
                end
            end
        end
        if (oe_watch && miso_oe) oe_seen = 1'b1;
    end

    // MISO monitor: host samples on SCLK rise while the target drives.
    always @(posedge sclk or posedge cs) begin
        if (cs) begin
            rx_cnt = 0;
        end else if (miso_oe) begin
            rx_byte = {rx_byte[6:0], miso};
            rx_cnt++;
            if (rx_cnt == 8) begin
                rx_cnt = 0;
                n_cmp++;
                if (exp_miso_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL miso_unexpected: got %02h, required none", rx_byte);
                end else begin
                    rx_exp = exp_miso_q.pop_front();
                    if (rx_byte !== rx_exp) begin
                        n_fail++;
                        $display("FAIL miso_byte: got %02h, required %02h", rx_byte, rx_exp);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic exp_rd(input logic [15:0] a);
        exp_q.push_back({1'b0, a, 8'h00});
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({1'b1, a, d});
    endtask

    task automatic spi_bit(input logic b);
        mosi = b;
        repeat (hp) @(negedge clk);
        sclk = 1'b1;
        repeat (hp) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic cs_assert();
        @(negedge clk);
        cs = 1'b0;
        repeat (hp) @(negedge clk);
    endtask

    task automatic cs_release();
        repeat (hp) @(negedge clk);
        cs = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_read_1234();
        exp_rd(16'h1234); exp_rd(16'h1235); exp_rd(16'h1236);
        exp_miso_q.push_back(8'hA5); exp_miso_q.push_back(8'h5A);
        cs_assert();
        spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h12); spi_byte(8'h34);
        spi_byte(8'h00); spi_byte(8'h00);
        cs_release();
        check("busy_after_read", busy, 0);
    endtask

    task automatic test_write_0010();
        exp_wr(16'h0010, 8'hDE); exp_wr(16'h0011, 8'hAD);
        cs_assert();
        spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h10);
        spi_byte(8'hDE); spi_byte(8'hAD);
        cs_release();
        check("wdata_last", mem_wdata, 8'hAD);
    endtask

    initial begin
        mem[16'h1234] = 8'hA5;
        mem[16'h1235] = 8'h5A;
        mem[16'h1236] = 8'h3C;
        mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h22;
        mem[16'h0001] = 8'h33;

        repeat (4) @(negedge clk);
        check("rst_miso", miso, 0);
        check("rst_oe", miso_oe, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_wr", mem_wr, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        test_read_1234();
        test_write_0010();

        // Address wraps past the top of the memory.
        exp_rd(16'hFFFF); exp_rd(16'h0000); exp_rd(16'h0001);
        exp_miso_q.push_back(8'h11); exp_miso_q.push_back(8'h22);
        cs_assert();
        spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'hFF); spi_byte(8'hFF);
        spi_byte(8'h00); spi_byte(8'h00);
        cs_release();

        // Unknown command: traffic is ignored until cs returns high.
        oe_seen = 1'b0;
        oe_watch = 1'b1;
        cs_assert();
        spi_byte(8'h9F); spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h12); spi_byte(8'h34);
        check("ignore_busy", busy, 1);
        repeat (hp) @(negedge clk);
        check("ignore_oe_seen", oe_seen, 0);
        cs_release();
        oe_watch = 1'b0;
        check("ignore_busy_released", busy, 0);

        // Write aborted mid-byte, then a normal read.
        cs_assert();
        spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h20);
        spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b0);
        cs_release();
        check("abort_busy", busy, 0);
        exp_rd(16'h1234); exp_rd(16'h1235);
        exp_miso_q.push_back(8'hA5);
        cs_assert();
        spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h12); spi_byte(8'h34);
        spi_byte(8'h00);
        cs_release();

        // Reset in the middle of a read with cs held low.
        exp_rd(16'h1234); exp_rd(16'h1235);
        cs_assert();
        spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h12); spi_byte(8'h34);
        spi_bit(1'b0); spi_bit(1'b0); spi_bit(1'b0); spi_bit(1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_miso", miso, 0);
        check("mid_rst_oe", miso_oe, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check("mid_rst_busy", busy, 0);
        reset = 1'b0;
        spi_bit(1'b0); spi_bit(1'b0); spi_bit(1'b0); spi_bit(1'b0);
        spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h12); spi_byte(8'h34);
        check("post_rst_busy_cs_low", busy, 0);
        check("post_rst_oe_cs_low", miso_oe, 0);
        cs_release();

        // Minimum legal SCLK half-period.
        hp = 4;
        test_read_1234();
        test_write_0010();

        repeat (20) @(negedge clk);
        check("strobe_queue_drained", exp_q.size(), 0);
        check("miso_queue_drained", exp_miso_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: run exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
